fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle control unit and datapath. Holds the PC and fetches 16-bit instructions over a request/grant/response memory handshake. Presents the instruction with its opcode[3:0] and funct[3:0] fields to decode under a valid/ready handshake. Computes the next PC from the branch decision returned by the datapath, and stops fetching on a halt opcode.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction at a time over a
// request/grant/response memory port and hands it to decode under valid/ready.
//
// state   | meaning
// S_IDLE  | waiting for start, no requests
// S_REQ   | imem_req high at pc, waiting for grant
// S_WAIT  | request granted, waiting for response data
// S_VALID | instruction presented to decode, waiting for id_ready
// S_HALT  | halt opcode consumed, fetch stopped until reset
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [3:0]         opcode_o,
  output logic [3:0]         funct_o,
  output logic [PC_W-1:0]    pc_o,
  input  logic               id_ready_i,
  input  logic               branch_taken_i,
  output logic               halted_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 accept;
  logic                 is_halt;
  logic [PC_W-1:0]      imm_sext;
  logic [PC_W-1:0]      pc_seq;

  assign accept   = (state_q == S_VALID) && id_ready_i;
  assign is_halt  = (instr_q[15:12] == HALT_OP);
  // Sign-extend (or truncate) imm8 to PC width; the adder then wraps modulo 2^PC_W.
  assign imm_sext = PC_W'($signed(instr_q[7:0]));
  assign pc_seq   = pc_q + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_REQ;
      S_REQ:   if (imem_gnt_i) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid_i) state_d = S_VALID;
      S_VALID: if (accept) state_d = is_halt ? S_HALT : S_REQ;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    halted_o      = 1'b0;
    unique case (state_q)
      S_REQ:   imem_req_o    = 1'b1;
      S_VALID: instr_valid_o = 1'b1;
      S_HALT:  halted_o      = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if ((state_q == S_WAIT) && imem_rvalid_i) begin
      instr_d = imem_rdata_i;
    end
    if (accept && !is_halt) begin
      pc_d = branch_taken_i ? (pc_seq + imm_sext) : pc_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign opcode_o    = instr_q[15:12];
  assign funct_o     = instr_q[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-PC instance and a RESET_PC=0xFF instance
// for the wrap cases, each backed by a zero-wait memory model or manual handshake.
module tb_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        bt;
    logic [7:0]  nxt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic id_ready = 1'b0, branch_taken = 1'b0;

  logic        req_a, req_b, gnt_a, gnt_b, rv_a, rv_b;
  logic [7:0]  addr_a, addr_b, pc_a, pc_b;
  logic [15:0] rd_a, rd_b, instr_a, instr_b;
  logic [3:0]  op_a, op_b, fn_a, fn_b;
  logic        valid_a, valid_b, halted_a, halted_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic        auto_a = 1'b1;
  logic        man_gnt_a = 1'b0, man_rv_a = 1'b0;
  logic [15:0] man_rd_a = 16'h0;
  logic        rvq_a, rvq_b;
  logic [15:0] rdq_a, rdq_b;

  int n_chk = 0;
  int n_fail = 0;
  bit use_b = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_gnt_i(gnt_a),
    .imem_rvalid_i(rv_a), .imem_rdata_i(rd_a),
    .instr_valid_o(valid_a), .instr_o(instr_a), .opcode_o(op_a), .funct_o(fn_a),
    .pc_o(pc_a), .id_ready_i(id_ready), .branch_taken_i(branch_taken), .halted_o(halted_a));

  fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'hFF), .HALT_OP(4'hF)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_gnt_i(gnt_b),
    .imem_rvalid_i(rv_b), .imem_rdata_i(rd_b),
    .instr_valid_o(valid_b), .instr_o(instr_b), .opcode_o(op_b), .funct_o(fn_b),
    .pc_o(pc_b), .id_ready_i(id_ready), .branch_taken_i(branch_taken), .halted_o(halted_b));

  // Zero-wait memory: grant in the request cycle, data the following cycle; drops on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvq_a <= 1'b0; rdq_a <= 16'h0;
      rvq_b <= 1'b0; rdq_b <= 16'h0;
    end else begin
      rvq_a <= auto_a & req_a;
      rdq_a <= mem_a[addr_a];
      rvq_b <= req_b;
      rdq_b <= mem_b[addr_b];
    end
  end

  assign gnt_a = auto_a ? req_a : man_gnt_a;
  assign rv_a  = auto_a ? rvq_a : man_rv_a;
  assign rd_a  = auto_a ? rdq_a : man_rd_a;
  assign gnt_b = req_b;
  assign rv_b  = rvq_b;
  assign rd_b  = rdq_b;

  logic        c_valid, c_req;
  logic [7:0]  c_pc, c_addr;
  logic [15:0] c_instr;
  logic [3:0]  c_op, c_fn;
  assign c_valid = use_b ? valid_b : valid_a;
  assign c_req   = use_b ? req_b   : req_a;
  assign c_pc    = use_b ? pc_b    : pc_a;
  assign c_addr  = use_b ? addr_b  : addr_a;
  assign c_instr = use_b ? instr_b : instr_a;
  assign c_op    = use_b ? op_b    : op_a;
  assign c_fn    = use_b ? fn_b    : fn_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!c_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", {31'd0, c_valid}, 32'd1);
  endtask

  // Entered at the negedge where the unit is in REQ for v.pc.
  task automatic run_vec(input vec_t v);
    int n;
    logic [3:0] e_op, e_fn;
    e_op = v.instr[15:12];
    e_fn = v.instr[3:0];
    chk("req_addr", {24'd0, c_addr}, {24'd0, v.pc});
    wait_valid(n);
    chk("gap", n, 32'd2);
    chk("pc", {24'd0, c_pc}, {24'd0, v.pc});
    chk("instr", {16'd0, c_instr}, {16'd0, v.instr});
    chk("opcode", {28'd0, c_op}, {28'd0, e_op});
    chk("funct", {28'd0, c_fn}, {28'd0, e_fn});
    branch_taken = v.bt;
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    branch_taken = 1'b0;
    chk("valid_drop", {31'd0, c_valid}, 32'd0);
    chk("next_req", {31'd0, c_req}, 32'd1);
    chk("next_addr", {24'd0, c_addr}, {24'd0, v.nxt});
  endtask

  vec_t va[9];
  vec_t vb[4];

  initial begin
    int n;
    va[0] = '{8'h00, 16'h0123, 1'b0, 8'h01};
    va[1] = '{8'h01, 16'h1045, 1'b0, 8'h02};
    va[2] = '{8'h02, 16'h4067, 1'b0, 8'h03};
    va[3] = '{8'h03, 16'h3001, 1'b1, 8'h05};
    va[4] = '{8'h05, 16'h30FE, 1'b1, 8'h04};
    va[5] = '{8'h04, 16'h2010, 1'b0, 8'h05};
    va[6] = '{8'h05, 16'h30FE, 1'b0, 8'h06};
    va[7] = '{8'h06, 16'h5A80, 1'b1, 8'h87};
    va[8] = '{8'h87, 16'h7000, 1'b0, 8'h88};
    vb[0] = '{8'hFF, 16'h1000, 1'b0, 8'h00};
    vb[1] = '{8'h00, 16'h30FC, 1'b1, 8'hFD};
    vb[2] = '{8'hFD, 16'h1000, 1'b0, 8'hFE};
    vb[3] = '{8'hFE, 16'h3005, 1'b1, 8'h04};
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    foreach (va[i]) mem_a[va[i].pc] = va[i].instr;
    foreach (vb[i]) mem_b[vb[i].pc] = vb[i].instr;
    mem_a[8'h88] = 16'h2033;
    mem_a[8'h89] = 16'hF000;

    // Reset values, during and after reset
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, req_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_req", {31'd0, req_a}, 32'd0);
    chk("idle_valid", {31'd0, valid_a}, 32'd0);
    chk("idle_pc", {24'd0, pc_a}, 32'd0);
    chk("idle_halted", {31'd0, halted_a}, 32'd0);
    chk("idle_instr", {16'd0, instr_a}, 32'd0);
    chk("idle_pc_b", {24'd0, pc_b}, 32'h0FF);

    // Sequential and branch table on instance A
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_req", {31'd0, req_a}, 32'd1);
    foreach (va[i]) run_vec(va[i]);

    // Stall at pc 0x88 with a branch pulse that must be ignored
    wait_valid(n);
    chk("stall_pc0", {24'd0, pc_a}, 32'h88);
    for (int i = 0; i < 5; i++) begin
      branch_taken = (i == 2);
      @(negedge clk);
      chk("stall_valid", {31'd0, valid_a}, 32'd1);
      chk("stall_pc", {24'd0, pc_a}, 32'h88);
      chk("stall_instr", {16'd0, instr_a}, 32'h2033);
      chk("stall_noreq", {31'd0, req_a}, 32'd0);
    end
    branch_taken = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    chk("post_stall_req", {31'd0, req_a}, 32'd1);
    chk("post_stall_addr", {24'd0, addr_a}, 32'h89);

    // Halt opcode is presented once, then fetch stops
    wait_valid(n);
    chk("halt_op", {28'd0, op_a}, 32'hF);
    chk("halt_pc", {24'd0, pc_a}, 32'h89);
    id_ready = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    branch_taken = 1'b0;
    chk("halted", {31'd0, halted_a}, 32'd1);
    chk("halt_valid", {31'd0, valid_a}, 32'd0);
    chk("halt_pc_hold", {24'd0, pc_a}, 32'h89);
    start_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      chk("halt_noreq", {31'd0, req_a}, 32'd0);
      chk("halt_stay", {31'd0, halted_a}, 32'd1);
    end

    // Wrap cases on instance B (RESET_PC = 0xFF)
    use_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("start_req_b", {31'd0, req_b}, 32'd1);
    foreach (vb[i]) run_vec(vb[i]);
    use_b = 1'b0;

    // Stale response in REQ, then reset during WAIT with a late response
    rst_n = 1'b0;
    auto_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_unhalt", {31'd0, halted_a}, 32'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("m_req", {31'd0, req_a}, 32'd1);
    chk("m_addr", {24'd0, addr_a}, 32'd0);
    man_rv_a = 1'b1;
    man_rd_a = 16'hBEEF;
    @(negedge clk);
    man_rv_a = 1'b0;
    chk("stale_req", {31'd0, req_a}, 32'd1);
    chk("stale_valid", {31'd0, valid_a}, 32'd0);
    man_gnt_a = 1'b1;
    @(negedge clk);
    man_gnt_a = 1'b0;
    chk("wait_noreq", {31'd0, req_a}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    man_rv_a = 1'b1;
    @(negedge clk);
    man_rv_a = 1'b0;
    chk("late_valid", {31'd0, valid_a}, 32'd0);
    chk("late_instr", {16'd0, instr_a}, 32'd0);
    chk("late_req", {31'd0, req_a}, 32'd0);
    @(negedge clk);
    chk("late_valid2", {31'd0, valid_a}, 32'd0);
    chk("late_idle_req", {31'd0, req_a}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
